// File: rtl/axis_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_ramp_pkg
// Brief    : Shared mode encodings and clamp helper for the axis ramp control.
// Revision : 1.0 - initial release
// ============================================================================
package axis_ramp_pkg;

    localparam logic MODE_HOLD   = 1'b0;
    localparam logic MODE_SPRING = 1'b1;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_ramp_channel.sv
`default_nettype none
// ============================================================================
// Module   : axis_ramp_channel
// Brief    : One axis: ramp register with acceleration, analog conditioning,
//            bumpless handover and registered output.
// Revision : 1.0 - initial release
// ============================================================================
module axis_ramp_channel
    import axis_ramp_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 254,
    parameter int CENTER      = 127,
    parameter int STEP        = 1,
    parameter int ACCEL_TICKS = 32,
    parameter int ACCEL_STEP  = 4,
    parameter bit INVERT      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_mode,
    input  logic             i_analog_sel,
    input  logic [WIDTH-1:0] i_analog,
    output logic [WIDTH-1:0] o_value,
    output logic             o_at_max,
    output logic             o_at_min
);

    localparam int               c_acc_w   = $clog2(ACCEL_TICKS + 1);
    localparam logic [WIDTH-1:0] c_min     = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] c_max     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_center  = WIDTH'(CENTER);
    localparam logic [WIDTH-1:0] c_sign    = WIDTH'(1) << (WIDTH - 1);
    localparam logic [c_acc_w-1:0] c_acc_sat = c_acc_w'(ACCEL_TICKS);
    localparam logic [c_acc_w-1:0] c_acc_one = c_acc_w'(1);

    logic [WIDTH-1:0]   r_ramp;
    logic [WIDTH-1:0]   r_value;
    logic [c_acc_w-1:0] r_acc;
    logic               r_dir;
    logic               r_sel_d;
    logic               r_at_max;
    logic               r_at_min;

    logic [WIDTH-1:0]   w_u;
    logic [WIDTH-1:0]   w_analog;
    logic [WIDTH-1:0]   w_reset_val;
    logic [WIDTH-1:0]   w_ramp_next;
    logic [c_acc_w-1:0] w_acc_next;
    logic               w_dir_next;
    int                 w_step;
    int                 w_next;

    // Flipping the sign bit offsets two's complement to unsigned; inversion is ~u.
    always_comb begin
        w_u = i_analog ^ c_sign;
        if (INVERT) begin
            w_u = ~w_u;
        end
        w_analog = WIDTH'(clamp(int'(w_u), MIN_VAL, MAX_VAL));
    end

    assign w_reset_val = (i_mode == MODE_HOLD) ? c_min : c_center;

    always_comb begin
        w_ramp_next = r_ramp;
        w_acc_next  = r_acc;
        w_dir_next  = r_dir;
        w_step      = STEP;
        w_next      = int'(r_ramp);
        if (i_analog_sel) begin
            w_acc_next = '0;
        end else if (r_sel_d) begin
            // Handover takes priority over a coincident tick.
            w_ramp_next = r_value;
            w_acc_next  = '0;
        end else if (i_tick) begin
            if (i_inc ^ i_dec) begin
                if ((r_acc != '0) && (r_dir == i_inc)) begin
                    w_acc_next = (r_acc == c_acc_sat) ? r_acc : r_acc + 1'b1;
                end else begin
                    w_acc_next = c_acc_one;
                end
                w_dir_next = i_inc;
                w_step     = (w_acc_next == c_acc_sat) ? ACCEL_STEP : STEP;
                w_next     = i_inc ? int'(r_ramp) + w_step : int'(r_ramp) - w_step;
            end else begin
                w_acc_next = '0;
                if (!i_inc && (i_mode == MODE_SPRING)) begin
                    if (r_ramp < c_center) begin
                        w_next = clamp(int'(r_ramp) + STEP, MIN_VAL, CENTER);
                    end else begin
                        w_next = clamp(int'(r_ramp) - STEP, CENTER, MAX_VAL);
                    end
                end
            end
            w_ramp_next = WIDTH'(clamp(w_next, MIN_VAL, MAX_VAL));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ramp   <= w_reset_val;
            r_value  <= w_reset_val;
            r_acc    <= '0;
            r_dir    <= 1'b0;
            r_sel_d  <= 1'b0;
            r_at_max <= (w_reset_val == c_max);
            r_at_min <= (w_reset_val == c_min);
        end else begin
            r_ramp   <= w_ramp_next;
            r_acc    <= w_acc_next;
            r_dir    <= w_dir_next;
            r_sel_d  <= i_analog_sel;
            // Holding the last analog value during handover keeps the output bumpless.
            r_value  <= i_analog_sel ? w_analog : (r_sel_d ? r_value : r_ramp);
            r_at_max <= (r_ramp == c_max);
            r_at_min <= (r_ramp == c_min);
        end
    end

    assign o_value  = r_value;
    assign o_at_max = r_at_max;
    assign o_at_min = r_at_min;

endmodule
`default_nettype wire

// File: rtl/axis_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axis_ramp_ctrl
// Brief    : Multi-channel ramp/analog control synthesiser with shared tick.
// Revision : 1.0 - initial release
// ============================================================================
module axis_ramp_ctrl
    import axis_ramp_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 8,
    parameter int TICK_DIV    = 196_850,
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 254,
    parameter int CENTER      = 127,
    parameter int STEP        = 1,
    parameter int ACCEL_TICKS = 32,
    parameter int ACCEL_STEP  = 4,
    parameter bit INVERT      = 1'b1
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       analog_sel,
    input  logic [CHANNELS*WIDTH-1:0] analog_in,
    output logic [CHANNELS*WIDTH-1:0] value_out,
    output logic [CHANNELS-1:0]       at_max,
    output logic [CHANNELS-1:0]       at_min
);

    localparam int                c_cnt_w = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_tick;

    assign w_tick = (r_cnt == c_last);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        axis_ramp_channel #(
            .WIDTH       (WIDTH),
            .MIN_VAL     (MIN_VAL),
            .MAX_VAL     (MAX_VAL),
            .CENTER      (CENTER),
            .STEP        (STEP),
            .ACCEL_TICKS (ACCEL_TICKS),
            .ACCEL_STEP  (ACCEL_STEP),
            .INVERT      (INVERT)
        ) u_ch (
            .clk          (clk_sys),
            .rst          (reset),
            .i_tick       (w_tick),
            .i_inc        (inc[i]),
            .i_dec        (dec[i]),
            .i_mode       (mode[i]),
            .i_analog_sel (analog_sel[i]),
            .i_analog     (analog_in[i*WIDTH +: WIDTH]),
            .o_value      (value_out[i*WIDTH +: WIDTH]),
            .o_at_max     (at_max[i]),
            .o_at_min     (at_min[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_ramp_ctrl
// Brief    : Self-checking bench for axis_ramp_ctrl (scoreboard + vector table).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_ramp_ctrl;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int TD = 4;
    localparam int AT = 4;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [CH-1:0]     inc;
    logic [CH-1:0]     dec;
    logic [CH-1:0]     mode;
    logic [CH-1:0]     analog_sel;
    logic [CH*W-1:0]   analog_in;
    logic [CH*W-1:0]   value_out;
    logic [CH-1:0]     at_max;
    logic [CH-1:0]     at_min;

    always #5 clk_sys = ~clk_sys;

    axis_ramp_ctrl #(
        .TICK_DIV    (TD),
        .ACCEL_TICKS (AT)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .inc        (inc),
        .dec        (dec),
        .mode       (mode),
        .analog_sel (analog_sel),
        .analog_in  (analog_in),
        .value_out  (value_out),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    typedef struct {
        string name;
        int    ch;
        int    kind;   // 0 value_out, 1 at_max, 2 at_min
        int    exp;
    } exp_t;

    typedef struct {
        logic [W-1:0] ain;
        int           exp;
    } avec_t;

    exp_t  sb[$];
    avec_t atab[6];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    ph       = 0;
    bit    ticked   = 1'b0;

    task automatic clk1();
        @(posedge clk_sys);
        ticked = (ph == TD - 1);
        ph     = ticked ? 0 : ph + 1;
        #1;
    endtask

    task automatic to_tick();
        for (int k = 0; k < TD; k++) begin
            clk1();
            if (ticked) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL tick_sync: no tick within %0d cycles", TD);
    endtask

    task automatic expect_v(input string n, input int ch, input int kind, input int e);
        exp_t x;
        x.name = n;
        x.ch   = ch;
        x.kind = kind;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic check_sb();
        exp_t        x;
        logic [31:0] act;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.kind)
                0:       act = {24'd0, value_out[x.ch*W +: W]};
                1:       act = {31'd0, at_max[x.ch]};
                default: act = {31'd0, at_min[x.ch]};
            endcase
            n_checks++;
            if (act !== x.exp) begin
                n_fail++;
                $display("FAIL %s ch%0d: got %0d, expected %0d", x.name, x.ch, act, x.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        int cnt;
        int st;

        atab[0] = '{8'h80, 254};
        atab[1] = '{8'h00, 127};
        atab[2] = '{8'h7F, 0};
        atab[3] = '{8'hFF, 128};
        atab[4] = '{8'h01, 126};
        atab[5] = '{8'hD8, 167};

        reset      = 1'b1;
        inc        = '0;
        dec        = '0;
        mode       = 2'b10;
        analog_sel = '0;
        analog_in  = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        expect_v("rst_val", 0, 0, 0);
        expect_v("rst_min", 0, 2, 1);
        expect_v("rst_max", 0, 1, 0);
        expect_v("rst_val", 1, 0, 127);
        expect_v("rst_min", 1, 2, 0);
        check_sb();
        reset = 1'b0;
        ph    = 0;

        // ch0 hold: inc ramps with acceleration and saturates at MAX_VAL
        e   = 0;
        cnt = 0;
        inc[0] = 1'b1;
        for (int t = 0; t < 68; t++) begin
            to_tick();
            cnt = (cnt < AT) ? cnt + 1 : AT;
            st  = (cnt == AT) ? 4 : 1;
            e   = (e + st > 254) ? 254 : e + st;
            expect_v("inc_ramp", 0, 0, e);
            expect_v("spring_idle", 1, 0, 127);
            clk1();
            check_sb();
        end
        expect_v("sat_max", 0, 1, 1);
        expect_v("sat_min", 0, 2, 0);
        check_sb();
        inc[0] = 1'b0;

        // ch1 spring: dec with acceleration, then return to CENTER
        e   = 127;
        cnt = 0;
        dec[1] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            to_tick();
            cnt = (cnt < AT) ? cnt + 1 : AT;
            st  = (cnt == AT) ? 4 : 1;
            e   = (e - st < 0) ? 0 : e - st;
            expect_v("dec_ramp", 1, 0, e);
            clk1();
            check_sb();
        end
        dec[1] = 1'b0;
        for (int t = 0; t < 34; t++) begin
            to_tick();
            e = (e < 127) ? e + 1 : e;
            expect_v("spring_ret", 1, 0, e);
            expect_v("hold_keep", 0, 0, 254);
            clk1();
            check_sb();
        end

        // ch0 to 50 via analog handover, then inc+dec together
        analog_sel[0] = 1'b1;
        analog_in[0*W +: W] = 8'd77;
        expect_v("ana_50", 0, 0, 50);
        clk1();
        check_sb();
        analog_sel[0] = 1'b0;
        expect_v("handover_50", 0, 0, 50);
        clk1();
        check_sb();
        inc[0] = 1'b1;
        dec[0] = 1'b1;
        for (int t = 0; t < 5; t++) begin
            to_tick();
            expect_v("both_hold", 0, 0, 50);
            clk1();
            check_sb();
        end
        dec[0] = 1'b0;
        e   = 50;
        cnt = 0;
        for (int t = 0; t < 4; t++) begin
            to_tick();
            cnt = (cnt < AT) ? cnt + 1 : AT;
            st  = (cnt == AT) ? 4 : 1;
            e   = e + st;
            expect_v("after_both", 0, 0, e);
            clk1();
            check_sb();
        end
        inc[0] = 1'b0;

        // analog path vectors on ch1, one cycle latency each
        analog_sel[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            analog_in[1*W +: W] = atab[i].ain;
            expect_v("analog", 1, 0, atab[i].exp);
            clk1();
            check_sb();
        end

        // handover on a tick edge with inc already requested: no step applied
        for (int k = 0; k < TD && ph != TD - 1; k++) begin
            clk1();
        end
        analog_sel[1] = 1'b0;
        inc[1]        = 1'b1;
        expect_v("ho_tick", 1, 0, 167);
        clk1();
        check_sb();
        expect_v("ho_after", 1, 0, 167);
        clk1();
        check_sb();
        to_tick();
        expect_v("ho_inc", 1, 0, 168);
        clk1();
        check_sb();
        inc[1] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
